parking_gate_ctrl: RTL and testbench

- Upstream front-end between raw parking sensors and the parking top-level logic.
- Synchronises and debounces the five presence sensors (3 slots, entrance, exit).
- Runs one gate state machine each for the entrance and exit gates.
- Outputs clean slot status, full/empty/occupancy, gate-open drives and one-cycle car_enter/car_exit pulses for the rush-hour, car-tracking and display stages.

---
 rtl/parking_gate_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Parking sensor front-end: 2-flop sync + debounce on five sensors, plus entrance/exit gate FSMs.
// Optional OPEN-state timeout with sticky gate_fault flags: define PARKING_GATE_TIMEOUT_EN.

module parking_gate_ctrl_debounce #(
    parameter int unsigned DEB_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int unsigned CW = $clog2(DEB_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The flip fires on the cycle the counter would reach DEB_CYC, so the count never wraps.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = db_q;
endmodule

module parking_gate_ctrl_fsm #(
    parameter int unsigned HOLD_CYC    = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic sens,
    input  logic allow,
    output logic gate_open,
    output logic car_pulse,
    output logic fault
);
    localparam int unsigned HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          open_q, open_d;
    logic          pulse_q, pulse_d;
    logic          lock;

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          fault_q, fault_d;
    logic          lock_q, lock_d;
    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        pulse_d = 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
        tmo_d   = '0;
        fault_d = fault_q;
        lock_d  = lock_q & sens;
`endif
        case (state_q)
            IDLE: begin
                if (sens && allow && !lock) state_d = OPEN;
            end
            OPEN: begin
                if (!sens) begin
                    state_d = HOLD;
                    pulse_d = 1'b1;
                end
`ifdef PARKING_GATE_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    // Timed-out gate may not reopen until the sensor has been seen low.
                    state_d = HOLD;
                    fault_d = 1'b1;
                    lock_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (sens && !lock) begin
                    state_d = OPEN;
                end else if (hold_q == HW'(HOLD_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        open_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            open_q  <= 1'b0;
            pulse_q <= 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
            tmo_q   <= '0;
            fault_q <= 1'b0;
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            open_q  <= open_d;
            pulse_q <= pulse_d;
`ifdef PARKING_GATE_TIMEOUT_EN
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
            lock_q  <= lock_d;
`endif
        end
    end

    assign gate_open = open_q;
    assign car_pulse = pulse_q;
`ifdef PARKING_GATE_TIMEOUT_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif
endmodule

module parking_gate_ctrl #(
    parameter int unsigned DEB_CYC     = 500_000,
    parameter int unsigned HOLD_CYC    = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] presence_slot_raw,
    input  logic       presence_entrance_raw,
    input  logic       presence_exit_raw,
    output logic [2:0] parking_status,
    output logic       slot_full,
    output logic       slot_empty,
    output logic [1:0] occupancy,
    output logic       open_entrance,
    output logic       open_exit,
    output logic       car_enter,
    output logic       car_exit,
    output logic [1:0] gate_fault
);
    logic ent_db, ext_db;
    logic ent_fault, ext_fault;

    for (genvar i = 0; i < 3; i++) begin : g_slot
        parking_gate_ctrl_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk (clk),
            .rst (reset),
            .din (presence_slot_raw[i]),
            .dout(parking_status[i])
        );
    end

    parking_gate_ctrl_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ent (
        .clk (clk),
        .rst (reset),
        .din (presence_entrance_raw),
        .dout(ent_db)
    );

    parking_gate_ctrl_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ext (
        .clk (clk),
        .rst (reset),
        .din (presence_exit_raw),
        .dout(ext_db)
    );

    assign slot_full  = &parking_status;
    assign slot_empty = ~|parking_status;
    assign occupancy  = {1'b0, parking_status[0]} + {1'b0, parking_status[1]}
                      + {1'b0, parking_status[2]};

    parking_gate_ctrl_fsm #(.HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) u_fsm_ent (
        .clk      (clk),
        .rst      (reset),
        .sens     (ent_db),
        .allow    (~slot_full),
        .gate_open(open_entrance),
        .car_pulse(car_enter),
        .fault    (ent_fault)
    );

    parking_gate_ctrl_fsm #(.HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) u_fsm_ext (
        .clk      (clk),
        .rst      (reset),
        .sens     (ext_db),
        .allow    (1'b1),
        .gate_open(open_exit),
        .car_pulse(car_exit),
        .fault    (ext_fault)
    );

    assign gate_fault = {ext_fault, ent_fault};
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with DEB_CYC=4, HOLD_CYC=8, TIMEOUT_CYC=20.
module tb_parking_gate_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] slot_raw;
    logic       ent_raw, ext_raw;
    logic [2:0] parking_status;
    logic       slot_full, slot_empty;
    logic [1:0] occupancy;
    logic       open_entrance, open_exit, car_enter, car_exit;
    logic [1:0] gate_fault;

    int total  = 0;
    int passed = 0;

    parking_gate_ctrl #(.DEB_CYC(4), .HOLD_CYC(8), .TIMEOUT_CYC(20)) dut (
        .clk                  (clk),
        .reset                (reset),
        .presence_slot_raw    (slot_raw),
        .presence_entrance_raw(ent_raw),
        .presence_exit_raw    (ext_raw),
        .parking_status       (parking_status),
        .slot_full            (slot_full),
        .slot_empty           (slot_empty),
        .occupancy            (occupancy),
        .open_entrance        (open_entrance),
        .open_exit            (open_exit),
        .car_enter            (car_enter),
        .car_exit             (car_exit),
        .gate_fault           (gate_fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        int pulses, pulses2, first_t, last_t, gap, seen_open;

        // Reset held with all slots occupied
        reset = 1'b1; slot_raw = 3'b111; ent_raw = 1'b1; ext_raw = 1'b1;
        tick(3);
        check("rst_status", 32'(parking_status), 0);
        check("rst_empty",  32'(slot_empty), 1);
        check("rst_full",   32'(slot_full), 0);
        check("rst_occ",    32'(occupancy), 0);
        check("rst_gates",  32'({open_entrance, open_exit, car_enter, car_exit}), 0);
        check("rst_fault",  32'(gate_fault), 0);

        reset = 1'b0; ent_raw = 1'b0; ext_raw = 1'b0;
        tick(5);
        check("deb_edge5", 32'(parking_status), 0);
        tick(1);
        check("deb_edge6", 32'(parking_status), 7);
        check("deb_occ3",  32'(occupancy), 3);
        check("deb_full",  32'(slot_full), 1);
        check("deb_empty", 32'(slot_empty), 0);

        slot_raw = 3'b001;
        tick(10);
        check("slot001", 32'(parking_status), 1);
        check("occ1",    32'(occupancy), 1);
        check("full0",   32'(slot_full), 0);

        // Glitch of 3 cycles is rejected
        ent_raw = 1'b1; tick(3); ent_raw = 1'b0;
        seen_open = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (open_entrance || car_enter) seen_open = 1;
        end
        check("glitch", 32'(seen_open), 0);

        // Normal entrance pass
        ent_raw = 1'b1;
        tick(6);
        check("ent_open_e6", 32'(open_entrance), 0);
        tick(1);
        check("ent_open_e7", 32'(open_entrance), 1);
        tick(3);
        ent_raw = 1'b0;
        pulses = 0; first_t = -1;
        for (int t = 1; t <= 16; t++) begin
            tick(1);
            if (car_enter) begin pulses++; if (first_t < 0) first_t = t; end
            if (t == 14) check("ent_hold_open", 32'(open_entrance), 1);
            if (t == 15) check("ent_closed", 32'(open_entrance), 0);
        end
        check("ent_pulses", 32'(pulses), 1);
        check("ent_pulse_t", 32'(first_t), 7);

        // Lot full: entrance blocked, exit served
        slot_raw = 3'b111;
        tick(10);
        check("full1", 32'(slot_full), 1);
        ent_raw = 1'b1; ext_raw = 1'b1;
        pulses = 0; pulses2 = 0; seen_open = 0;
        for (int t = 1; t <= 50; t++) begin
            if (t == 31) begin ent_raw = 1'b0; ext_raw = 1'b0; end
            tick(1);
            if (open_entrance) seen_open = 1;
            if (car_enter) pulses++;
            if (car_exit) pulses2++;
            if (t == 6) check("ext_open_e6", 32'(open_exit), 0);
            if (t == 7) check("ext_open_e7", 32'(open_exit), 1);
        end
        check("full_ent_open", 32'(seen_open), 0);
        check("full_car_enter", 32'(pulses), 0);
        check("ext_pulses", 32'(pulses2), 1);
        check("ext_closed", 32'(open_exit), 0);

        // Re-entry during HOLD
        slot_raw = 3'b001;
        tick(10);
        ent_raw = 1'b1; tick(10); ent_raw = 1'b0;
        pulses = 0; first_t = -1; last_t = -1; gap = 0;
        for (int t = 1; t <= 35; t++) begin
            if (t == 8) ent_raw = 1'b1;
            if (t == 14) ent_raw = 1'b0;
            tick(1);
            if (car_enter) begin pulses++; if (first_t < 0) first_t = t; last_t = t; end
            if (t <= 27 && !open_entrance) gap = 1;
            if (t == 28) check("reentry_closed", 32'(open_entrance), 0);
        end
        check("reentry_gap", 32'(gap), 0);
        check("reentry_pulses", 32'(pulses), 2);
        check("reentry_first", 32'(first_t), 7);
        check("reentry_second", 32'(last_t), 20);

`ifdef PARKING_GATE_TIMEOUT_EN
        ent_raw = 1'b1;
        pulses = 0;
        for (int t = 1; t <= 40; t++) begin
            tick(1);
            if (car_enter) pulses++;
            if (t == 26) check("tmo_fault_e26", 32'(gate_fault), 0);
            if (t == 27) check("tmo_fault_e27", 32'(gate_fault), 1);
            if (t == 34) check("tmo_hold_open", 32'(open_entrance), 1);
            if (t == 35) check("tmo_closed", 32'(open_entrance), 0);
        end
        check("tmo_locked", 32'(open_entrance), 0);
        check("tmo_no_pulse", 32'(pulses), 0);
        ent_raw = 1'b0;
        tick(15);
        check("tmo_sticky", 32'(gate_fault), 1);
        ent_raw = 1'b1;
        tick(7);
        check("tmo_reopen", 32'(open_entrance), 1);
        tick(24);
        check("tmo_midhold", 32'(open_entrance), 1);
        reset = 1'b1; #1;
        check("tmo_rst_open", 32'(open_entrance), 0);
        check("tmo_rst_fault", 32'(gate_fault), 0);
`else
        ent_raw = 1'b1;
        pulses = 0;
        for (int t = 1; t <= 40; t++) begin
            tick(1);
            if (car_enter) pulses++;
        end
        check("notmo_open", 32'(open_entrance), 1);
        check("notmo_fault", 32'(gate_fault), 0);
        check("notmo_pulse", 32'(pulses), 0);
        ent_raw = 1'b0;
        tick(10);
        check("midhold_open", 32'(open_entrance), 1);
        reset = 1'b1; #1;
        check("rst_mid_open", 32'(open_entrance), 0);
        check("rst_mid_pulse", 32'(car_enter), 0);
`endif
        tick(2);
        check("rst_final", 32'({open_entrance, open_exit, car_enter, car_exit, gate_fault}), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
